ro_freq_counter: RTL and testbench
==================================

# ro_freq_counter

Gated edge counter that measures the frequency of the ring-oscillator signal selected by the 16:1 output multiplexer stage. It sits directly downstream of that multiplexer, sampling its output in the Wishbone clock domain. It counts rising edges over a programmable window of reference-clock cycles and exposes the result through a Wishbone classic slave. This gives firmware an on-chip frequency readout without external test equipment.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes BASE_ADDR+0x00..0x0C.
- CNT_W, 32, width of the edge counter, the gate counter and the GATE register.
- wb_clk_i  in  1  reference clock; all logic runs on it.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- ro_i  in  1  asynchronous oscillator signal from the output multiplexer.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic controls.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte enables; writes update only the enabled bytes.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- busy_o  out  1  a measurement is in progress.
- done_o  out  1  the result is valid; level signal.

## Operation
- Registers:
  - 0x00 CTRL (W): bit0 START, self-clearing, reads 0; bit1 CONT, re-arms automatically after DONE.
  - 0x04 GATE (R/W): window length in wb_clk_i cycles; reset value 1000.
  - 0x08 COUNT (R): last completed result.
  - 0x0C STATUS (R): bit0 busy, bit1 done, bit2 ovf. Writing 1 to bit1 clears done; writing 1 to bit2 clears ovf.
- Input path: 2-FF synchroniser on ro_i, then an edge register. Rising edge = sync2 & ~sync3.
- The count is exact only for f_ro < f_clk/2. Faster oscillators alias; this is a documented limitation, not detected in hardware.
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE → ARM on a START write:
  - If GATE==0: go straight to DONE, COUNT=0, done set.
  - Otherwise: latch GATE into gate_cnt and clear edge_cnt.
- ARM: one cycle to flush the synchroniser → COUNT. Edges seen during ARM are discarded.
- COUNT: each cycle, decrement gate_cnt and add the edge flag to edge_cnt. When gate_cnt reaches 1 on a cycle → DONE. That final cycle's edge is counted.
- DONE: COUNT register := edge_cnt, done=1, busy=0. Next state: ARM if CONT=1, otherwise IDLE.
- Saturation: edge_cnt stops at all-ones and sets ovf, which is sticky until cleared by W1C.
- START while busy is ignored. A GATE write while busy takes effect on the next measurement.
- Writing CONT=0 mid-measurement lets the current window finish, then the FSM returns to IDLE.
- A simultaneous START write and done-clear write is legal: done clears and the new measurement begins.
- Reads of unmapped offsets inside the window return 0. Writes to read-only registers are ignored.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, busy_o=0, done_o=0, COUNT=0, GATE=1000, CTRL=0, ovf=0, FSM=IDLE.
- Wishbone ack: asserted in the cycle after cyc&stb&address-hit, held for exactly one cycle, never back-to-back for the same request. Read data is valid with ack.
- START to busy_o: busy_o rises 1 cycle after the acked START write (the ARM entry cycle).
- Measurement: 1 ARM cycle plus GATE COUNT cycles, then the DONE cycle. done_o rises GATE+2 cycles after busy_o rises.
- ro_i to count latency: 3 cycles. Edges arriving within the last 3 cycles of a window fall into the next window, or are lost if the FSM returns to IDLE.
- Reset mid-measurement clears everything immediately, asynchronously. No partial result is retained.

## Structure
- Shared package ro_meas_pkg: the FSM state enum, the register offset constants (CTRL/GATE/COUNT/STATUS), the GATE reset constant and the STATUS bit indices.
- One natural sub-module, ro_edge_sync: 2-FF synchroniser plus rising-edge detector, reusable for other asynchronous oscillator taps.
- The top level holds the Wishbone decode, the register file, the FSM and the counters.

## Test plan
- Reset: assert wb_rst_ni=0 mid-measurement → all outputs and registers at reset values; STATUS reads 0; GATE reads 1000.
- Basic measurement: ro_i toggles every 4 clk (period 8), GATE=800, START → done_o after 802 cycles; COUNT=100 ±1; busy_o high for 801 cycles.
- GATE=0 then START → done immediately, COUNT=0, busy never asserts.
- Saturation: CNT_W=8, ro_i period 4, GATE=2000 → COUNT=255, STATUS.ovf=1; W1C to bit2 clears ovf.
- Continuous mode: CONT=1, GATE=100 → done pulses repeatedly, COUNT updates every 102 cycles; a START write while busy is ignored (no restart); CONT=0 → the FSM stops after the current window.
- Bus: byte-masked GATE write with sel=4'b0001 and data 0xFF → GATE=0x3FF (upper bytes of 1000 kept); every request gets exactly one ack; an unmapped offset 0x10 inside the window reads 0.

Source files
------------

// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency counter: FSM states,
// register map offsets, reset constants and STATUS/CTRL bit positions.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } meas_state_t;

  // Decoded address window is 256 bytes; only the first four words are mapped.
  localparam int ADDR_WIN_W = 8;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_GATE   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  localparam logic [31:0] GATE_RST = 32'd1000;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  function automatic logic state_is_busy(input meas_state_t st);
    return (st == ST_ARM) || (st == ST_COUNT);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for an asynchronous oscillator tap followed by an edge
// register; rise is high for one cycle per synchronised rising edge.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised value.
  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], async_in};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/ro_freq_counter.sv
// Gated rising-edge counter for a ring-oscillator tap with a Wishbone classic
// register interface (CTRL, GATE, COUNT, STATUS).
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CNT_W     = 32,
  // The gate may be made wider than the edge counter so that a narrow counter
  // can still be driven into saturation.
  parameter int          GATE_W    = CNT_W
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        ro_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [31:0] GATE_RST_VAL = GATE_RST;

  meas_state_t       state_reg, state_next;
  logic              ack_reg;
  logic [31:0]       dat_reg;
  logic              cont_reg;
  logic [GATE_W-1:0] gate_reg;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              done_reg, done_next;
  logic              ovf_reg, ovf_next;

  logic              ro_edge;
  logic              addr_hit;
  logic [7:0]        offset;
  logic              bus_req;
  logic              wr_req;
  logic              rd_req;
  logic              wr_ctrl_b0;
  logic              wr_gate;
  logic              wr_status_b0;
  logic              start_accept;
  logic              clr_done;
  logic              clr_ovf;
  logic              busy;
  logic              load_window;
  logic              edge_sat;
  logic [31:0]       gate_wide;
  logic [31:0]       gate_merged;
  logic [31:0]       rd_data;

  ro_edge_sync u_edge_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .async_in (ro_i),
    .rise     (ro_edge)
  );

  // Bus decode: ack_reg masks the request so a held strobe never sees two acks in a row.
  assign addr_hit = (wbs_adr_i[31:ADDR_WIN_W] == BASE_ADDR[31:ADDR_WIN_W]);
  assign offset   = wbs_adr_i[7:0];
  assign bus_req  = wbs_cyc_i & wbs_stb_i & addr_hit & ~ack_reg;
  assign wr_req   = bus_req & wbs_we_i;
  assign rd_req   = bus_req & ~wbs_we_i;

  assign wr_ctrl_b0   = wr_req && (offset == OFF_CTRL) && wbs_sel_i[0];
  assign wr_gate      = wr_req && (offset == OFF_GATE);
  assign wr_status_b0 = wr_req && (offset == OFF_STATUS) && wbs_sel_i[0];

  assign busy         = state_is_busy(state_reg);
  assign start_accept = wr_ctrl_b0 && wbs_dat_i[CTRL_START] && !busy;
  assign clr_done     = wr_status_b0 && wbs_dat_i[STAT_DONE];
  assign clr_ovf      = wr_status_b0 && wbs_dat_i[STAT_OVF];
  assign edge_sat     = (edge_cnt_reg == {CNT_W{1'b1}});

  assign gate_wide = 32'(gate_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gate_lane
      assign gate_merged[8*gi +: 8] = wbs_sel_i[gi] ? wbs_dat_i[8*gi +: 8]
                                                    : gate_wide[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_CTRL:   rd_data[CTRL_CONT] = cont_reg;
      OFF_GATE:   rd_data = gate_wide;
      OFF_COUNT:  rd_data = 32'(count_reg);
      OFF_STATUS: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done_reg;
        rd_data[STAT_OVF]  = ovf_reg;
      end
      default:    rd_data = '0;
    endcase
  end

  // A zero-length gate skips ARM/COUNT and produces an immediate zero result.
  always_comb begin
    state_next  = state_reg;
    load_window = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_accept) begin
          load_window = 1'b1;
          state_next  = (gate_reg == '0) ? ST_DONE : ST_ARM;
        end
      end
      ST_ARM: begin
        state_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (gate_cnt_reg == GATE_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cont_reg || start_accept) begin
          load_window = 1'b1;
          state_next  = (gate_reg == '0) ? ST_DONE : ST_ARM;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // done is a level that a new window (ARM) or a W1C clears; a fresh result wins.
  always_comb begin
    done_next = done_reg;
    if (clr_done || (state_reg == ST_ARM)) begin
      done_next = 1'b0;
    end
    if (state_reg == ST_DONE) begin
      done_next = 1'b1;
    end
  end

  always_comb begin
    ovf_next = ovf_reg;
    if (clr_ovf) begin
      ovf_next = 1'b0;
    end
    if ((state_reg == ST_COUNT) && ro_edge && edge_sat) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg    <= ST_IDLE;
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
      cont_reg     <= 1'b0;
      gate_reg     <= GATE_RST_VAL[GATE_W-1:0];
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= bus_req;
      dat_reg   <= rd_req ? rd_data : '0;
      done_reg  <= done_next;
      ovf_reg   <= ovf_next;

      if (wr_ctrl_b0) begin
        cont_reg <= wbs_dat_i[CTRL_CONT];
      end
      if (wr_gate) begin
        gate_reg <= gate_merged[GATE_W-1:0];
      end

      if (load_window) begin
        edge_cnt_reg <= '0;
        gate_cnt_reg <= gate_reg;
      end else if (state_reg == ST_COUNT) begin
        gate_cnt_reg <= gate_cnt_reg - GATE_W'(1);
        if (ro_edge && !edge_sat) begin
          edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
        end
      end

      if (state_reg == ST_DONE) begin
        count_reg <= edge_cnt_reg;
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign busy_o    = busy;
  assign done_o    = done_reg;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: register table, basic, zero-gate,
// continuous, saturation (narrow counter instance) and mid-measurement reset.
module tb_ro_freq_counter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst_n;
  logic        ro;
  logic        cyc0, stb0, cyc1, stb1;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        ack0, ack1;
  logic [31:0] rdat0, rdat1;
  logic        busy0, busy1;
  logic        done0, done1;

  int ro_half = 0;
  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int ack_cnt = 0;
  int xfer_cnt = 0;
  int b2b = 0;
  logic done_prev = 1'b0;
  logic ack0_prev = 1'b0;
  logic ack1_prev = 1'b0;
  int done_times[$];

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    bit          we;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  ro_freq_counter #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .ro_i(ro),
    .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_ack_o(ack0), .wbs_dat_o(rdat0), .busy_o(busy0), .done_o(done0)
  );

  ro_freq_counter #(.BASE_ADDR(BASE), .CNT_W(8), .GATE_W(32)) dut_sat (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .ro_i(ro),
    .wbs_cyc_i(cyc1), .wbs_stb_i(stb1), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_ack_o(ack1), .wbs_dat_o(rdat1), .busy_o(busy1), .done_o(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: edges land 3 ns past a 10 ns grid, never on a clock edge.
  initial begin
    ro = 1'b0;
    #3;
    forever begin
      if (ro_half == 0) begin
        ro = 1'b0;
        #10;
      end else begin
        #(ro_half) ro = ~ro;
      end
    end
  end

  always @(negedge clk) begin
    if (done0 && !done_prev) done_times.push_back(cyc_cnt);
    if (ack0 && ack0_prev) b2b <= b2b + 1;
    if (ack1 && ack1_prev) b2b <= b2b + 1;
    if (ack0) ack_cnt <= ack_cnt + 1;
    if (ack1) ack_cnt <= ack_cnt + 1;
    done_prev <= done0;
    ack0_prev <= ack0;
    ack1_prev <= ack1;
    cyc_cnt   <= cyc_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout, got no event expected event", name);
  endtask

  task automatic wb_xfer(input int tgt, input bit we_b, input logic [7:0] off,
                         input logic [31:0] data, input logic [3:0] sel_b,
                         input logic [31:0] exp, input bit use_sb, input string name,
                         output logic [31:0] rdata);
    int  n;
    bit  got;
    sb_t e;
    adr  = BASE | {24'h0, off};
    wdat = data;
    we   = we_b;
    sel  = sel_b;
    if (tgt == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end
    else          begin cyc1 = 1'b1; stb1 = 1'b1; end
    if (!we_b && use_sb) begin
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
    xfer_cnt++;
    n = 0;
    got = 1'b0;
    rdata = '0;
    while (!got && n < 16) begin
      tick();
      n++;
      got = (tgt == 0) ? ack0 : ack1;
    end
    if (got) begin
      rdata = (tgt == 0) ? rdat0 : rdat1;
      $display("xfer %-18s tgt=%0d we=%0d off=0x%02h wdata=0x%08h rdata=0x%08h",
               name, tgt, we_b, off, data, rdata);
      if (!we_b && use_sb) begin
        e = sb_q.pop_front();
        check(e.name, rdata, e.exp);
      end
    end else begin
      fail_now({name, "_ack"});
      if (!we_b && use_sb) void'(sb_q.pop_front());
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int tgt, input logic [7:0] off, input logic [31:0] data, input string name);
    logic [31:0] dummy;
    wb_xfer(tgt, 1'b1, off, data, 4'hF, 32'h0, 1'b0, name, dummy);
  endtask

  task automatic rd_chk(input int tgt, input logic [7:0] off, input logic [31:0] exp, input string name);
    logic [31:0] dummy;
    wb_xfer(tgt, 1'b0, off, 32'h0, 4'hF, exp, 1'b1, name, dummy);
  endtask

  task automatic rd_val(input int tgt, input logic [7:0] off, input string name, output logic [31:0] v);
    wb_xfer(tgt, 1'b0, off, 32'h0, 4'hF, 32'h0, 1'b0, name, v);
  endtask

  task automatic wait_rises(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (done_times.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (done_times.size() < n) fail_now(name);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    int k;

    vecs[0]  = '{"gate_rst",      1'b0, 8'h04, 32'h0,        4'hF, 32'd1000};
    vecs[1]  = '{"count_rst",     1'b0, 8'h08, 32'h0,        4'hF, 32'h0};
    vecs[2]  = '{"status_rst",    1'b0, 8'h0C, 32'h0,        4'hF, 32'h0};
    vecs[3]  = '{"ctrl_rst",      1'b0, 8'h00, 32'h0,        4'hF, 32'h0};
    vecs[4]  = '{"gate_wr_b0",    1'b1, 8'h04, 32'h0000_00FF, 4'b0001, 32'h0};
    vecs[5]  = '{"gate_b0",       1'b0, 8'h04, 32'h0,        4'hF, 32'h0000_03FF};
    vecs[6]  = '{"gate_wr_b13",   1'b1, 8'h04, 32'h1234_5678, 4'b1010, 32'h0};
    vecs[7]  = '{"gate_b13",      1'b0, 8'h04, 32'h0,        4'hF, 32'h1200_56FF};
    vecs[8]  = '{"unmapped_10",   1'b0, 8'h10, 32'h0,        4'hF, 32'h0};
    vecs[9]  = '{"count_wr",      1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[10] = '{"count_ro",      1'b0, 8'h08, 32'h0,        4'hF, 32'h0};
    vecs[11] = '{"status_w1c_nop",1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[12] = '{"status_idle",   1'b0, 8'h0C, 32'h0,        4'hF, 32'h0};
    vecs[13] = '{"unmapped_fc",   1'b0, 8'hFC, 32'h0,        4'hF, 32'h0};

    rst_n = 1'b0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    we = 1'b0; adr = '0; wdat = '0; sel = '0;
    repeat (3) tick();
    check("rst_ack",  32'(ack0),  32'h0);
    check("rst_dat",  rdat0,      32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    rst_n = 1'b1;
    tick();

    // Register map table
    for (int i = 0; i < 14; i++) begin
      wb_xfer(0, vecs[i].we, vecs[i].off, vecs[i].wdata, vecs[i].sel,
              vecs[i].exp, 1'b1, vecs[i].name, v);
    end

    // Basic measurement: period 8 clk, GATE 800
    wr(0, 8'h04, 32'd800, "gate_800");
    ro_half = 40;
    repeat (4) tick();
    wr(0, 8'h00, 32'h1, "start");
    check("busy_at_arm", 32'(busy0), 32'h1);
    n = 0;
    while (busy0 && n < 2000) begin n++; tick(); end
    check("busy_cycles", 32'(n), 32'd801);
    k = n;
    while (!done0 && k < 3000) begin k++; tick(); end
    check("done_latency", 32'(k), 32'd802);
    rd_val(0, 8'h08, "count_basic", v);
    check_range("count_basic", v, 32'd99, 32'd101);
    rd_chk(0, 8'h0C, 32'h2, "status_done");

    // Zero-length gate
    wr(0, 8'h0C, 32'h2, "clr_done");
    rd_chk(0, 8'h0C, 32'h0, "status_cleared");
    wr(0, 8'h04, 32'h0, "gate_0");
    wr(0, 8'h00, 32'h1, "start_g0");
    check("g0_no_busy", 32'(busy0), 32'h0);
    tick();
    check("g0_busy_after", 32'(busy0), 32'h0);
    check("g0_done", 32'(done0), 32'h1);
    rd_chk(0, 8'h08, 32'h0, "g0_count");

    // Continuous mode
    wr(0, 8'h0C, 32'h2, "clr_done2");
    wr(0, 8'h04, 32'd100, "gate_100");
    done_times.delete();
    wr(0, 8'h00, 32'h3, "start_cont");
    wait_rises(3, 600, "cont_rises3");
    if (done_times.size() >= 3) begin
      check("cont_period1", 32'(done_times[1] - done_times[0]), 32'd102);
      check("cont_period2", 32'(done_times[2] - done_times[1]), 32'd102);
    end
    rd_val(0, 8'h08, "count_cont", v);
    check_range("count_cont", v, 32'd12, 32'd13);
    wait_rises(4, 300, "cont_rises4");
    repeat (20) tick();
    wr(0, 8'h00, 32'h3, "start_while_busy");
    wait_rises(5, 300, "cont_rises5");
    if (done_times.size() >= 5) begin
      check("cont_no_restart", 32'(done_times[4] - done_times[3]), 32'd102);
    end
    repeat (20) tick();
    wr(0, 8'h00, 32'h0, "cont_off");
    wait_rises(6, 300, "cont_last");
    repeat (250) tick();
    check("cont_stop_rises", 32'(done_times.size()), 32'd6);
    check("cont_stop_busy", 32'(busy0), 32'h0);
    rd_chk(0, 8'h0C, 32'h2, "cont_stop_status");

    // Saturation on the 8-bit instance: period 4 clk, GATE 2000
    ro_half = 20;
    wr(1, 8'h04, 32'd2000, "sat_gate");
    wr(1, 8'h00, 32'h1, "sat_start");
    k = 0;
    while (!done1 && k < 2600) begin k++; tick(); end
    if (!done1) fail_now("sat_done");
    rd_chk(1, 8'h08, 32'd255, "sat_count");
    rd_chk(1, 8'h0C, 32'h6, "sat_status");
    wr(1, 8'h0C, 32'h4, "sat_clr_ovf");
    rd_chk(1, 8'h0C, 32'h2, "sat_ovf_cleared");

    // Reset in the middle of a measurement
    wr(0, 8'h00, 32'h1, "start_pre_rst");
    repeat (30) tick();
    check("busy_pre_rst", 32'(busy0), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy0), 32'h0);
    check("rst_async_done", 32'(done1), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd_chk(0, 8'h0C, 32'h0, "status_after_rst");
    rd_chk(0, 8'h04, 32'd1000, "gate_after_rst");
    rd_chk(0, 8'h08, 32'h0, "count_after_rst");
    rd_chk(1, 8'h04, 32'd1000, "sat_gate_after_rst");
    rd_chk(1, 8'h0C, 32'h0, "sat_status_after_rst");

    tick();
    check("ack_per_req", 32'(ack_cnt), 32'(xfer_cnt));
    check("ack_b2b", 32'(b2b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
